// File: rtl/capture_ctrl.sv
// capture_ctrl: capture-side controller for the scope trigger path.
// Writes decimated samples into a circular RAM, arms the trigger once
// enough pre-trigger history is stored, counts post-trigger samples, then
// pulses set_capture_done and holds the buffer until readout acknowledges.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   run               start a new capture (acted on only in IDLE)
//   wrt_smpl          decimator sample strobe
//   trig_pos          number of post-trigger samples, latched on run
//   triggered         latched trigger from trigger logic
//   capture_ack       readout has consumed the buffer
//   armed             enables the trigger latch
//   set_capture_done  one-cycle pulse that clears the trigger latch
//   we, addr          RAM write enable (combinational) and write address
//   trig_addr         RAM address of the first post-trigger sample
//   capture_done      buffer complete, awaiting readout
module capture_ctrl #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              wrt_smpl,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              triggered,
  input  logic              capture_ack,
  output logic              armed,
  output logic              set_capture_done,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              capture_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W-1:0] r_trig_addr, w_trig_addr_nxt;
  logic [ADDR_W-1:0] r_tp_lat, w_tp_lat_nxt;
  logic [ADDR_W-1:0] r_post_cnt, w_post_cnt_nxt;
  logic [CNT_W-1:0]  r_pre_cnt, w_pre_cnt_nxt;
  logic              r_armed, w_armed_nxt;
  logic              r_scd, w_scd_nxt;
  logic              r_cdone, w_cdone_nxt;
  logic              w_we;

  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_post_inc;
  logic [CNT_W-1:0]  w_pre_inc;
  logic [CNT_W-1:0]  w_pre_target;

  assign w_addr_inc   = r_addr + ADDR_W'(1);
  assign w_post_inc   = r_post_cnt + ADDR_W'(1);
  assign w_pre_inc    = r_pre_cnt + CNT_W'(1);
  // tp_lat of 0 yields a target of DEPTH, i.e. a full buffer of history
  assign w_pre_target = CNT_W'(DEPTH) - CNT_W'(r_tp_lat);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_trig_addr <= '0;
      r_tp_lat    <= '0;
      r_post_cnt  <= '0;
      r_pre_cnt   <= '0;
      r_armed     <= 1'b0;
      r_scd       <= 1'b0;
      r_cdone     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_trig_addr <= w_trig_addr_nxt;
      r_tp_lat    <= w_tp_lat_nxt;
      r_post_cnt  <= w_post_cnt_nxt;
      r_pre_cnt   <= w_pre_cnt_nxt;
      r_armed     <= w_armed_nxt;
      r_scd       <= w_scd_nxt;
      r_cdone     <= w_cdone_nxt;
    end
  end

  // Next-state, datapath updates and write enable
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_trig_addr_nxt = r_trig_addr;
    w_tp_lat_nxt    = r_tp_lat;
    w_post_cnt_nxt  = r_post_cnt;
    w_pre_cnt_nxt   = r_pre_cnt;
    w_armed_nxt     = r_armed;
    w_scd_nxt       = 1'b0;
    w_cdone_nxt     = r_cdone;
    w_we            = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_armed_nxt = 1'b0;
        if (run) begin
          w_state_nxt    = S_PRE;
          w_addr_nxt     = '0;
          w_pre_cnt_nxt  = '0;
          w_post_cnt_nxt = '0;
          w_tp_lat_nxt   = trig_pos;
        end
      end

      S_PRE: begin
        w_we = wrt_smpl;
        if (wrt_smpl) begin
          w_addr_nxt    = w_addr_inc;
          w_pre_cnt_nxt = w_pre_inc;
          if (w_pre_inc == w_pre_target) begin
            w_state_nxt = S_ARMED;
            w_armed_nxt = 1'b1;
          end
        end
      end

      S_ARMED: begin
        w_we = wrt_smpl;
        if (wrt_smpl) w_addr_nxt = w_addr_inc;
        if (triggered) begin
          // A write in the trigger cycle still belongs to the pre-trigger data
          w_state_nxt     = S_POST;
          w_armed_nxt     = 1'b0;
          w_trig_addr_nxt = wrt_smpl ? w_addr_inc : r_addr;
          w_post_cnt_nxt  = '0;
        end
      end

      S_POST: begin
        if (r_tp_lat == '0) begin
          // No post-trigger samples requested: finish without writing
          w_state_nxt = S_DONE;
          w_scd_nxt   = 1'b1;
          w_cdone_nxt = 1'b1;
        end else begin
          w_we = wrt_smpl;
          if (wrt_smpl) begin
            w_addr_nxt     = w_addr_inc;
            w_post_cnt_nxt = w_post_inc;
            if (w_post_inc == r_tp_lat) begin
              w_state_nxt = S_DONE;
              w_scd_nxt   = 1'b1;
              w_cdone_nxt = 1'b1;
            end
          end
        end
      end

      S_DONE: begin
        if (capture_ack) begin
          w_state_nxt = S_IDLE;
          w_cdone_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign we               = w_we;
  assign addr             = r_addr;
  assign trig_addr        = r_trig_addr;
  assign armed            = r_armed;
  assign set_capture_done = r_scd;
  assign capture_done     = r_cdone;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with ADDR_W=4 (DEPTH=16).
module tb_capture_ctrl;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       wrt_smpl;
  logic [3:0] trig_pos;
  logic       triggered;
  logic       capture_ack;
  logic       armed;
  logic       set_capture_done;
  logic       we;
  logic [3:0] addr;
  logic [3:0] trig_addr;
  logic       capture_done;

  capture_ctrl #(.ADDR_W(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .run              (run),
    .wrt_smpl         (wrt_smpl),
    .trig_pos         (trig_pos),
    .triggered        (triggered),
    .capture_ack      (capture_ack),
    .armed            (armed),
    .set_capture_done (set_capture_done),
    .we               (we),
    .addr             (addr),
    .trig_addr        (trig_addr),
    .capture_done     (capture_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       run;
    logic       wrt;
    logic       trg;
    logic       ack;
    logic [3:0] tp;
    logic       e_we;
    logic       e_armed;
    logic       e_scd;
    logic       e_cdone;
    logic [3:0] e_addr;
    logic [3:0] e_taddr;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void add(input logic r, input logic w, input logic t,
                              input logic a, input logic [3:0] tp,
                              input logic ewe, input logic earm,
                              input logic escd, input logic ecd,
                              input logic [3:0] eaddr, input logic [3:0] etaddr);
    vec_t v;
    v.run = r; v.wrt = w; v.trg = t; v.ack = a; v.tp = tp;
    v.e_we = ewe; v.e_armed = earm; v.e_scd = escd; v.e_cdone = ecd;
    v.e_addr = eaddr; v.e_taddr = etaddr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic t,
                       input logic a, input logic [3:0] tp);
    run = r; wrt_smpl = w; triggered = t; capture_ack = a; trig_pos = tp;
  endtask

  // we is checked before the edge, registered outputs just after it
  task automatic apply(input vec_t v, input int idx);
    drive(v.run, v.wrt, v.trg, v.ack, v.tp);
    #1;
    chk($sformatf("v%0d.we", idx), 4'(we), 4'(v.e_we));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d.armed", idx), 4'(armed), 4'(v.e_armed));
    chk($sformatf("v%0d.scd", idx), 4'(set_capture_done), 4'(v.e_scd));
    chk($sformatf("v%0d.cdone", idx), 4'(capture_done), 4'(v.e_cdone));
    chk($sformatf("v%0d.addr", idx), addr, v.e_addr);
    chk($sformatf("v%0d.taddr", idx), trig_addr, v.e_taddr);
  endtask

  task automatic step(input logic r, input logic w, input logic t,
                      input logic a, input logic [3:0] tp);
    drive(r, w, t, a, tp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int writes;
    int post;
    logic w;

    // trig_pos=4: 12 pre writes arm, trigger on 20th write, 4 post writes
    add(1, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++)
      add(0, 1, (k == 20), 0, 4, 1, (k >= 12 && k < 20), 0, 0,
          4'(k % 16), (k == 20) ? 4'd4 : 4'd0);
    for (int k = 21; k <= 24; k++)
      add(0, 1, 0, 0, 4, 1, 0, (k == 24), (k == 24), 4'(k - 16), 4'd4);
    add(0, 1, 0, 0, 4, 0, 0, 0, 1, 8, 4);   // strobe in DONE not written
    add(1, 0, 0, 0, 4, 0, 0, 0, 1, 8, 4);   // run in DONE ignored
    add(1, 0, 0, 1, 4, 0, 0, 0, 0, 8, 4);   // run with ack: only ack taken
    add(0, 1, 0, 0, 4, 0, 0, 0, 0, 8, 4);   // still IDLE, run was dropped
    // trig_pos=0: 16 pre writes, triggered held through PRE, no post writes
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4);
    for (int k = 1; k <= 16; k++)
      add(0, 1, 1, 0, 0, 1, (k == 16), 0, 0, 4'(k % 16), 4'd4);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);   // trigger, no write: trig_addr=0
    add(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);   // POST with tp=0: done, no write
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);   // pulse is one cycle
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);   // ack

    // Reset
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    chk("rst.armed", 4'(armed), 4'd0);
    chk("rst.we", 4'(we), 4'd0);
    chk("rst.addr", addr, 4'd0);
    chk("rst.taddr", trig_addr, 4'd0);
    chk("rst.cdone", 4'(capture_done), 4'd0);
    chk("rst.scd", 4'(set_capture_done), 4'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Gapped strobes, trig_pos=12, triggered held high during PRE
    step(1, 0, 1, 0, 12);
    writes = 0;
    for (int i = 0; i < 12; i++) begin
      w = (i % 3 == 2);
      drive(0, w, 1, 0, 0);
      #1;
      chk("gap.pre.we", 4'(we), 4'(w));
      @(posedge clk);
      #1;
      if (w) writes++;
      chk("gap.pre.addr", addr, 4'(writes));
      chk("gap.pre.armed", 4'(armed), 4'(writes == 4));
    end
    step(0, 0, 1, 0, 0);
    chk("gap.trig.armed", 4'(armed), 4'd0);
    chk("gap.trig.taddr", trig_addr, 4'd4);
    post = 0;
    for (int i = 0; i < 36; i++) begin
      w = (i % 3 == 2);
      step(0, w, 0, 0, 0);
      if (w) post++;
      chk("gap.post.addr", addr, 4'((4 + post) % 16));
      chk("gap.post.scd", 4'(set_capture_done), 4'(w && post == 12));
    end
    chk("gap.cdone", 4'(capture_done), 4'd1);
    step(0, 1, 0, 0, 0);
    chk("gap.scd_low", 4'(set_capture_done), 4'd0);
    chk("gap.addr_frozen", addr, 4'd0);
    step(0, 0, 0, 1, 0);
    chk("gap.ack", 4'(capture_done), 4'd0);

    // Async reset in the middle of POST
    step(1, 0, 0, 0, 8);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
    chk("ar.armed", 4'(armed), 4'd1);
    step(0, 1, 1, 0, 0);
    chk("ar.taddr", trig_addr, 4'd9);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("ar.post_addr", addr, 4'd11);
    drive(0, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.rst.armed", 4'(armed), 4'd0);
    chk("ar.rst.we", 4'(we), 4'd0);
    chk("ar.rst.addr", addr, 4'd0);
    chk("ar.rst.taddr", trig_addr, 4'd0);
    chk("ar.rst.cdone", 4'(capture_done), 4'd0);
    chk("ar.rst.scd", 4'(set_capture_done), 4'd0);
    #4 rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Capture-side controller for the scope's trigger path. It sits on the opposite end of the armed / triggered / set_capture_done handshake from the trigger latch.
- It writes decimated samples into a circular sample RAM and arms the trigger once enough pre-trigger history has been stored.
- After the trigger it counts a programmed number of post-trigger samples, then pulses set_capture_done to clear the trigger latch.
- It holds the captured buffer until readout acknowledges it.

Parameters:
- ADDR_W, 9, sample RAM address width; DEPTH = 2**ADDR_W entries.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- run  input  1  1-cycle pulse: start a new capture (ignored unless IDLE)
- wrt_smpl  input  1  1-cycle strobe from decimator: a sample is valid this cycle
- trig_pos  input  ADDR_W  number of post-trigger samples; latched on accepted run
- triggered  input  1  latched trigger from trigger logic
- capture_ack  input  1  1-cycle pulse from readout: buffer consumed
- armed  output  1  enables trigger latch
- set_capture_done  output  1  1-cycle pulse; clears trigger latch
- we  output  1  RAM write enable
- addr  output  ADDR_W  RAM write address
- trig_addr  output  ADDR_W  RAM address of first post-trigger sample
- capture_done  output  1  buffer complete, awaiting readout

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All state is on posedge clk, with async clear on negedge rst_n.
- Reset values:
  - armed=0, set_capture_done=0, capture_done=0.
  - addr=0, trig_addr=0, state=IDLE.
  - Internal counters are 0.
- Reset mid-capture aborts to IDLE with the same values.
- States and transitions:
  - IDLE -> PRE on run. On entry: addr<=0, pre_cnt<=0, post_cnt<=0, tp_lat<=trig_pos.
  - PRE -> ARMED when pre_cnt reaches DEPTH - tp_lat.
  - ARMED -> POST when triggered=1.
  - POST -> DONE when post_cnt reaches tp_lat.
  - DONE -> IDLE on capture_ack.
- Writes:
  - we = wrt_smpl while state is PRE, ARMED or POST (combinational, same cycle as the strobe); we=0 in IDLE and DONE.
  - addr is registered and gives the current write location; it increments on every write.
  - addr wraps from DEPTH-1 to 0.
- pre_cnt:
  - Width ADDR_W+1; increments per write in PRE.
  - armed is registered and goes to 1 on the cycle after the write that makes pre_cnt == DEPTH - tp_lat.
  - tp_lat=0 therefore means DEPTH pre-samples are required.
- ARMED:
  - Writes continue and wrap freely.
  - armed=1 throughout ARMED.
- ARMED with triggered high:
  - state<=POST and armed<=0.
  - trig_addr<=addr value after any same-cycle increment, so a same-cycle write counts as pre-trigger.
  - post_cnt<=0.
- POST:
  - post_cnt increments per write.
  - On the write that makes post_cnt == tp_lat: state<=DONE, set_capture_done<=1 for exactly one cycle, capture_done<=1.
  - If tp_lat==0, the DONE transition and the set_capture_done pulse occur on the cycle after POST is entered, with no further writes.
- DONE:
  - capture_done stays 1; addr and trig_addr are frozen.
  - wrt_smpl is ignored.
  - On capture_ack: capture_done<=0, state<=IDLE.
- Ignored inputs:
  - run is ignored outside IDLE.
  - capture_ack is ignored outside DONE.
  - triggered is ignored outside ARMED.
- Simultaneous events:
  - run together with capture_ack in DONE: only the ack is acted on; the run is dropped.
  - A wrt_smpl on the same cycle as run in IDLE is not written.

Test Plan:
- Reset, ADDR_W=4 -> armed=0, we=0, addr=0, capture_done=0, set_capture_done=0; async assert mid-POST returns all to these values immediately.
- ADDR_W=4, trig_pos=4, run, wrt_smpl every cycle -> we=1 on each strobe; armed rises on the cycle after the 12th write (addr=12).
- Continue to 20 total writes with triggered=1 on the 20th write's cycle -> trig_addr=4, armed falls; 4 more writes, then set_capture_done is a single-cycle pulse; capture_done=1; addr=8 frozen; further strobes give we=0.
- In DONE, run pulse -> no change; capture_ack -> capture_done=0 next cycle; new run restarts from addr=0.
- trig_pos=0, ADDR_W=4 -> armed after 16 writes; on triggered, set_capture_done pulses the next cycle with zero post writes; trig_addr=0.
- triggered held high during PRE -> ignored, no transition until armed; strobes gapped (every 3rd cycle) -> counts advance only on strobes.
